gate_flop_array: RTL

GATE_FLOP_ARRAY -- requirements
Module: gate_flop_array

---
 rtl/gate_flop_pkg.sv | 14 +
 rtl/gate_flop_channel.sv | 54 +++++
 rtl/gate_flop_array.sv | 76 +++++++
 3 files changed

// File: rtl/gate_flop_pkg.sv
// Shared op-code definitions and reset defaults for the gate/flop array.
package gate_flop_pkg;

    localparam logic [1:0] OP_XOR  = 2'b00;
    localparam logic [1:0] OP_ANDN = 2'b01;
    localparam logic [1:0] OP_ORN  = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    // Reset pattern cycles XOR, ANDN, ORN across the stages.
    function automatic logic [1:0] default_op(input int unsigned idx);
        return 2'(idx % 3);
    endfunction

endpackage

// File: rtl/gate_flop_channel.sv
// One channel: ST stage flops driven by decoded per-stage ops, NOR output,
// and a saturating counter of cycles where the NOR was high while enabled.
module gate_flop_channel #(
    parameter int ST    = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             en,
    input  logic             clr,
    input  logic             x,
    input  logic [ST-1:0]    sel_xor,
    input  logic [ST-1:0]    sel_andn,
    input  logic [ST-1:0]    sel_orn,
    output logic             z,
    output logic [CNT_W-1:0] cnt
);

    logic [ST-1:0] q;
    logic [ST-1:0] q_next;
    logic [ST-1:0] x_vec;
    logic [ST-1:0] sel_hold;

    assign x_vec    = {ST{x}};
    assign sel_hold = ~(sel_xor | sel_andn | sel_orn);

    // Selects are one-hot per stage, so an AND-OR mux is sufficient.
    assign q_next = (sel_xor  & (x_vec ^ q))
                  | (sel_andn & x_vec & ~q)
                  | (sel_orn  & (x_vec | ~q))
                  | (sel_hold & q);

    assign z = ~|q;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            q <= '0;
        end else if (en) begin
            q <= q_next;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && z && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gate_flop_array.sv
// CH independent gate/flop channels sharing one bank of per-stage op registers.
module gate_flop_array
    import gate_flop_pkg::*;
#(
    parameter int CH    = 4,
    parameter int ST    = 3,
    parameter int CNT_W = 8,
    localparam int SW   = (ST > 1) ? $clog2(ST) : 1
) (
    input  logic                clk,
    input  logic                areset_n,
    input  logic                en,
    input  logic [CH-1:0]       x,
    input  logic                cfg_we,
    input  logic [SW-1:0]       cfg_stage,
    input  logic [1:0]          cfg_op,
    input  logic                clr,
    output logic [CH-1:0]       z,
    output logic                z_any,
    output logic [CH*CNT_W-1:0] z_cnt
);

    logic [1:0]    op_q [ST];
    logic [ST-1:0] sel_xor;
    logic [ST-1:0] sel_andn;
    logic [ST-1:0] sel_orn;

    // NOTE: the op bank is a handful of flops, so it is reset element by element.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < ST; i++) begin
                op_q[i] <= default_op(i);
            end
        end else if (cfg_we) begin
            // Out-of-range stage indices match no entry and are dropped.
            for (int i = 0; i < ST; i++) begin
                if (cfg_stage == SW'(i)) begin
                    op_q[i] <= cfg_op;
                end
            end
        end
    end

    // NOTE: defaults first so no path through the block can infer a latch.
    always_comb begin
        sel_xor  = '0;
        sel_andn = '0;
        sel_orn  = '0;
        for (int i = 0; i < ST; i++) begin
            sel_xor[i]  = (op_q[i] == OP_XOR);
            sel_andn[i] = (op_q[i] == OP_ANDN);
            sel_orn[i]  = (op_q[i] == OP_ORN);
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        gate_flop_channel #(
            .ST    (ST),
            .CNT_W (CNT_W)
        ) u_channel (
            .clk      (clk),
            .areset_n (areset_n),
            .en       (en),
            .clr      (clr),
            .x        (x[c]),
            .sel_xor  (sel_xor),
            .sel_andn (sel_andn),
            .sel_orn  (sel_orn),
            .z        (z[c]),
            .cnt      (z_cnt[c*CNT_W +: CNT_W])
        );
    end

    assign z_any = |z;

endmodule
